// File: rtl/bnn_operand_loader_if.sv
// Byte-stream input and operand-pair output bundle of the BNN operand loader.
interface bnn_operand_loader_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] input_data;
  logic [31:0] weight;
  logic        op_valid;
  logic        op_ready;
  logic        op_first;
  logic        op_last;
  logic        busy;

  modport master (
    output in_byte, in_valid, op_ready,
    input  in_ready, input_data, weight, op_valid, op_first, op_last, busy
  );

  modport slave (
    input  in_byte, in_valid, op_ready,
    output in_ready, input_data, weight, op_valid, op_first, op_last, busy
  );
endinterface

// File: rtl/bnn_operand_loader.sv
// Assembles little-endian byte streams into activation/weight word pairs for the
// BNN neuron and tags the first and last pair of every neuron evaluation.
module bnn_operand_loader #(
  parameter int WORDS = 4
) (
  input logic                 clock,
  input logic                 reset,
  bnn_operand_loader_if.slave bus
);

  localparam int PAIR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(WORDS - 1);
  localparam logic [PAIR_W-1:0] PAIR_ZERO = PAIR_W'(0);
  localparam logic [PAIR_W-1:0] PAIR_ONE  = PAIR_W'(1);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [2:0]        byte_cnt_r;
  logic [2:0]        byte_cnt_nxt_s;
  logic [PAIR_W-1:0] pair_cnt_r;
  logic [PAIR_W-1:0] pair_cnt_nxt_s;
  logic [31:0]       act_r;
  logic [31:0]       wgt_r;
  logic              in_ready_r;
  logic              op_valid_r;
  logic              op_first_r;
  logic              op_last_r;
  logic              busy_r;
  logic              byte_acc_s;
  logic              op_hs_s;

  // Transfer qualifiers; both depend only on registered state plus the peer's strobe.
  always_comb begin
    byte_acc_s = bus.in_valid && (state_r == ST_LOAD);
    op_hs_s    = op_valid_r && bus.op_ready;
  end

  // Next-state decode for the LOAD/ISSUE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (byte_acc_s && (byte_cnt_r == 3'd7)) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        if (op_hs_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Byte and pair counter updates; byte_cnt wraps naturally from 7 to 0.
  always_comb begin
    byte_cnt_nxt_s = byte_cnt_r;
    pair_cnt_nxt_s = pair_cnt_r;
    if (byte_acc_s) begin
      byte_cnt_nxt_s = byte_cnt_r + 3'd1;
    end else begin
      byte_cnt_nxt_s = byte_cnt_r;
    end
    if (op_hs_s) begin
      if (pair_cnt_r == LAST_PAIR) begin
        pair_cnt_nxt_s = PAIR_ZERO;
      end else begin
        pair_cnt_nxt_s = pair_cnt_r + PAIR_ONE;
      end
    end else begin
      pair_cnt_nxt_s = pair_cnt_r;
    end
  end

  // Controller state and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_LOAD;
      byte_cnt_r <= 3'd0;
      pair_cnt_r <= PAIR_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      pair_cnt_r <= pair_cnt_nxt_s;
    end
  end

  // Byte lanes: each lane loads only when its own byte is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_r <= 32'd0;
      wgt_r <= 32'd0;
    end else if (byte_acc_s) begin
      case (byte_cnt_r)
        3'd0:    act_r[7:0]   <= bus.in_byte;
        3'd1:    act_r[15:8]  <= bus.in_byte;
        3'd2:    act_r[23:16] <= bus.in_byte;
        3'd3:    act_r[31:24] <= bus.in_byte;
        3'd4:    wgt_r[7:0]   <= bus.in_byte;
        3'd5:    wgt_r[15:8]  <= bus.in_byte;
        3'd6:    wgt_r[23:16] <= bus.in_byte;
        3'd7:    wgt_r[31:24] <= bus.in_byte;
        default: begin
          act_r <= act_r;
          wgt_r <= wgt_r;
        end
      endcase
    end else begin
      act_r <= act_r;
      wgt_r <= wgt_r;
    end
  end

  // Status outputs are flops loaded from next-state values, so they line up with state_r.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready_r <= 1'b1;
      op_valid_r <= 1'b0;
      op_first_r <= 1'b0;
      op_last_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt_s == ST_LOAD);
      op_valid_r <= (state_nxt_s == ST_ISSUE);
      op_first_r <= (state_nxt_s == ST_ISSUE) && (pair_cnt_nxt_s == PAIR_ZERO);
      op_last_r  <= (state_nxt_s == ST_ISSUE) && (pair_cnt_nxt_s == LAST_PAIR);
      busy_r     <= (state_nxt_s == ST_ISSUE) || (byte_cnt_nxt_s != 3'd0) ||
                    (pair_cnt_nxt_s != PAIR_ZERO);
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.op_valid   = op_valid_r;
  assign bus.op_first   = op_first_r;
  assign bus.op_last    = op_last_r;
  assign bus.busy       = busy_r;
  assign bus.input_data = act_r;
  assign bus.weight     = wgt_r;

endmodule

// File: tb/tb_bnn_operand_loader.sv
// Scoreboard bench for bnn_operand_loader with WORDS=4 and WORDS=1 instances.
module tb_bnn_operand_loader;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
    logic        f;
    logic        l;
  } exp_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   pidx [2];
  exp_t q4 [$];
  exp_t q1 [$];
  exp_t e4;
  exp_t e1;

  bnn_operand_loader_if if4 ();
  bnn_operand_loader_if if1 ();

  bnn_operand_loader #(.WORDS(4)) dut4 (.clock(clock), .reset(reset), .bus(if4));
  bnn_operand_loader #(.WORDS(1)) dut1 (.clock(clock), .reset(reset), .bus(if1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] b);
    if (sel == 1) begin
      if1.in_valid = v;
      if1.in_byte  = b;
    end else begin
      if4.in_valid = v;
      if4.in_byte  = b;
    end
  endtask

  function automatic logic f_rdy(input int sel);
    return (sel == 1) ? if1.in_ready : if4.in_ready;
  endfunction

  function automatic logic f_opv(input int sel);
    return (sel == 1) ? if1.op_valid : if4.op_valid;
  endfunction

  task automatic send_byte(input int sel, input logic [7:0] b);
    int n;
    n = 0;
    drive(sel, 1'b1, b);
    while (!f_rdy(sel) && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clock); #1;
    drive(sel, 1'b0, 8'h00);
  endtask

  // Pushes the expected pair, then streams 8 bytes (first byte in stream[63:56]).
  task automatic send_pair(input int sel, input logic [63:0] s, input logic [31:0] ea,
                           input logic [31:0] ew, input int maxgap);
    exp_t e;
    int   words;
    int   gap;
    logic [63:0] sv;
    words = (sel == 1) ? 1 : 4;
    e.a = ea;
    e.w = ew;
    e.f = (pidx[sel] == 0);
    e.l = (pidx[sel] == words - 1);
    pidx[sel] = (pidx[sel] + 1) % words;
    if (sel == 1) q1.push_back(e);
    else q4.push_back(e);
    sv = s;
    for (int i = 0; i < 8; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(posedge clock); #1;
      end
      send_byte(sel, sv[63 - 8*i -: 8]);
    end
    check("op_valid_after_byte7", 64'(f_opv(sel)), 64'(1'b1));
    check("in_ready_in_issue", 64'(f_rdy(sel)), 64'(1'b0));
  endtask

  // Scoreboard monitor for the WORDS=4 instance.
  always @(negedge clock) begin
    if (!reset && if4.op_valid && if4.op_ready) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb4_unexpected: got pair 0x%0h/0x%0h, required none", if4.input_data, if4.weight);
      end else begin
        e4 = q4.pop_front();
        check("sb4_input_data", 64'(if4.input_data), 64'(e4.a));
        check("sb4_weight", 64'(if4.weight), 64'(e4.w));
        check("sb4_op_first", 64'(if4.op_first), 64'(e4.f));
        check("sb4_op_last", 64'(if4.op_last), 64'(e4.l));
      end
    end
  end

  // Scoreboard monitor for the WORDS=1 instance.
  always @(negedge clock) begin
    if (!reset && if1.op_valid && if1.op_ready) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb1_unexpected: got pair 0x%0h/0x%0h, required none", if1.input_data, if1.weight);
      end else begin
        e1 = q1.pop_front();
        check("sb1_input_data", 64'(if1.input_data), 64'(e1.a));
        check("sb1_weight", 64'(if1.weight), 64'(e1.w));
        check("sb1_op_first", 64'(if1.op_first), 64'(e1.f));
        check("sb1_op_last", 64'(if1.op_last), 64'(e1.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    pidx[0] = 0;
    pidx[1] = 0;
    reset   = 1'b1;
    if4.op_ready = 1'b1;
    if1.op_ready = 1'b1;
    drive(1, 1'b0, 8'h00);
    drive(0, 1'b1, 8'hAA);
    repeat (3) @(posedge clock);
    #1;
    check("rst_op_valid", 64'(if4.op_valid), 64'(1'b0));
    check("rst_input_data", 64'(if4.input_data), 64'd0);
    check("rst_weight", 64'(if4.weight), 64'd0);
    check("rst_op_first", 64'(if4.op_first), 64'(1'b0));
    check("rst_op_last", 64'(if4.op_last), 64'(1'b0));
    check("rst_busy", 64'(if4.busy), 64'(1'b0));
    check("rst_busy_w1", 64'(if1.busy), 64'(1'b0));
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    @(posedge clock); #1;
    check("post_rst_in_ready", 64'(if4.in_ready), 64'(1'b1));
    check("post_rst_busy", 64'(if4.busy), 64'(1'b0));

    // Single pair, pair index 0.
    send_pair(0, 64'h78563412_EFBEADDE, 32'h12345678, 32'hDEADBEEF, 0);
    @(posedge clock); #1;
    check("single_op_valid_drop", 64'(if4.op_valid), 64'(1'b0));
    check("single_busy_held", 64'(if4.busy), 64'(1'b1));
    check("single_in_ready", 64'(if4.in_ready), 64'(1'b1));

    // Backpressure on pair 1 while the source already holds the next byte.
    if4.op_ready = 1'b0;
    send_pair(0, 64'h01020304_A0B0C0D0, 32'h04030201, 32'hD0C0B0A0, 0);
    fork
      send_pair(0, 64'h11223344_55667788, 32'h44332211, 32'h88776655, 0);
      begin
        for (int c = 0; c < 5; c++) begin
          @(posedge clock); #1;
          check("bp_op_valid", 64'(if4.op_valid), 64'(1'b1));
          check("bp_in_ready", 64'(if4.in_ready), 64'(1'b0));
          check("bp_input_data", 64'(if4.input_data), 64'(32'h04030201));
          check("bp_weight", 64'(if4.weight), 64'(32'hD0C0B0A0));
          check("bp_tags", 64'({if4.op_first, if4.op_last}), 64'(2'b00));
        end
        if4.op_ready = 1'b1;
      end
    join

    // Pair 3 closes the evaluation.
    send_pair(0, 64'hFF000000_0000FF00, 32'h000000FF, 32'h00FF0000, 0);
    @(posedge clock); #1;
    check("eval_busy_drop", 64'(if4.busy), 64'(1'b0));
    check("eval_op_valid_drop", 64'(if4.op_valid), 64'(1'b0));

    // New evaluation, then the same words as pair 0 with random bubbles.
    send_pair(0, 64'hCAFEBABE_00010203, 32'hBEBAFECA, 32'h03020100, 0);
    send_pair(0, 64'h78563412_EFBEADDE, 32'h12345678, 32'hDEADBEEF, 3);

    // Pair 2 is cut short by reset after 5 bytes.
    send_byte(0, 8'h99);
    send_byte(0, 8'h88);
    send_byte(0, 8'h77);
    send_byte(0, 8'h66);
    send_byte(0, 8'h55);
    drive(0, 1'b1, 8'h33);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_input_data", 64'(if4.input_data), 64'd0);
    check("mid_rst_weight", 64'(if4.weight), 64'd0);
    check("mid_rst_busy", 64'(if4.busy), 64'(1'b0));
    check("mid_rst_op_valid", 64'(if4.op_valid), 64'(1'b0));
    check("mid_rst_in_ready", 64'(if4.in_ready), 64'(1'b1));
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    pidx[0] = 0;
    pidx[1] = 0;
    @(posedge clock); #1;
    check("after_mid_rst_busy", 64'(if4.busy), 64'(1'b0));
    send_pair(0, 64'hA5A5A5A5_5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    @(posedge clock); #1;

    // WORDS=1: every pair is both first and last.
    send_pair(1, 64'h01020304_05060708, 32'h04030201, 32'h08070605, 0);
    @(posedge clock); #1;
    check("w1_busy_p0", 64'(if1.busy), 64'(1'b0));
    check("w1_in_ready_p0", 64'(if1.in_ready), 64'(1'b1));
    send_pair(1, 64'h10203040_50607080, 32'h40302010, 32'h80706050, 0);
    @(posedge clock); #1;
    check("w1_busy_p1", 64'(if1.busy), 64'(1'b0));
    send_pair(1, 64'hFFEEDDCC_BBAA9988, 32'hCCDDEEFF, 32'h8899AABB, 0);
    @(posedge clock); #1;
    check("w1_busy_p2", 64'(if1.busy), 64'(1'b0));

    repeat (3) @(posedge clock);
    #1;
    check("sb4_drained", 64'(q4.size()), 64'd0);
    check("sb1_drained", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bnn_operand_loader.md
# bnn_operand_loader

Byte-serial front end that feeds the BNN neuron datapath. It receives 8-bit bytes over a valid/ready stream and assembles each pair of 32-bit words: one activation word, then one weight word. Each completed pair is presented to the neuron as `input_data`/`weight` under a valid/ready handshake. The block also tags the first and last pair of each neuron evaluation so the neuron can clear its accumulator and sample its activation.

## Interface
Parameters:
- `WORDS`, default 4: number of 32-bit word pairs per neuron evaluation. Legal range is 1..256.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_byte`, in, 8: serial operand byte.
- `in_valid`, in, 1: `in_byte` is valid.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `input_data`, out, 32: assembled activation word.
- `weight`, out, 32: assembled weight word.
- `op_valid`, out, 1: `input_data`/`weight` pair is valid.
- `op_ready`, in, 1: neuron accepts the pair this cycle.
- `op_first`, out, 1: the presented pair is pair 0 of an evaluation.
- `op_last`, out, 1: the presented pair is pair `WORDS-1` of an evaluation.
- `busy`, out, 1: a partial pair or partial evaluation is in progress.

## Operation
- **Two-state FSM**
  - `LOAD`: `in_ready`=1, `op_valid`=0.
  - `ISSUE`: `in_ready`=0, `op_valid`=1.
- **Byte transfer**
  - A byte moves when `in_valid && in_ready`.
  - `byte_cnt` (3 bits) counts accepted bytes 0..7.
- **Byte mapping, little-endian**
  - Bytes 0..3 form `input_data`: byte k goes to bits [8k+7:8k].
  - Bytes 4..7 form `weight`: byte k goes to bits [8(k-4)+7:8(k-4)].
  - A byte register is written only when its byte is accepted.
- **Transitions**
  - LOAD → ISSUE when byte 7 is accepted; `byte_cnt` wraps to 0.
  - ISSUE → LOAD on `op_valid && op_ready`.
- **Pair counter**
  - `pair_cnt` runs 0..`WORDS-1`.
  - It increments on each op handshake and wraps to 0 after `WORDS-1`.
- **Tags**
  - `op_first` = (`pair_cnt`==0).
  - `op_last` = (`pair_cnt`==`WORDS-1`).
  - Both are qualified by `op_valid`: they read 0 whenever `op_valid`=0.
  - With `WORDS`=1, both are 1 on every pair.
- **Hold rule:** while in ISSUE, `input_data`, `weight`, `op_first` and `op_last` hold stable until the handshake.
- **`busy`** = (state==ISSUE) || (`byte_cnt`!=0) || (`pair_cnt`!=0).
- **Simultaneous events**
  - In ISSUE, `in_valid` is ignored and no byte is consumed.
  - A byte and an op handshake never complete in the same cycle.
- **Reset**
  - State goes to LOAD, `byte_cnt`=0, `pair_cnt`=0.
  - `input_data`=0 and `weight`=0.
  - `op_valid`, `op_first`, `op_last` and `busy` are 0.
  - `in_ready` is 1 from the first cycle after reset deasserts.
  - Bytes presented while `reset`=1 are discarded.
  - A reset mid-pair or mid-evaluation discards all partial state.

## Timing
- `in_ready` and `op_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `op_ready`.
- `op_valid` rises the cycle after the edge that accepts byte 7.
- `in_ready` rises the cycle after the op handshake edge.
- Minimum 9 cycles per pair: 8 byte cycles plus 1 issue cycle with `op_ready`=1.
- Pending bytes are never lost. An upstream source holding `in_valid` through ISSUE has its byte accepted on the first LOAD cycle.

## Test plan
- **Single pair (`WORDS`=4):**
  - Stimulus: bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE back-to-back, `op_ready`=1.
  - Response: next cycle `op_valid`=1 with `input_data`=0x12345678, `weight`=0xDEADBEEF, `op_first`=1, `op_last`=0.
  - `op_valid` drops after 1 cycle; `busy` stays 1.
- **Backpressure:**
  - Stimulus: hold `op_ready`=0 for 5 cycles after a pair completes, with `in_valid`=1 throughout.
  - Response: `op_valid`, data and tags stay stable and `in_ready`=0.
  - No byte is consumed until the cycle after `op_ready` rises.
- **Full evaluation:**
  - Stimulus: 32 bytes, then 8 more.
  - Response: `op_first` reads 1,0,0,0 and `op_last` reads 0,0,0,1 across the four pairs.
  - `busy` drops after the 4th handshake; the 5th pair has `op_first`=1.
- **Bubbles:**
  - Stimulus: random `in_valid` gaps of 0-3 cycles between bytes.
  - Response: identical words and tags to gap-free input.
  - `op_valid` appears exactly 1 cycle after byte 7.
- **Reset mid-operation:**
  - Stimulus: pulse `reset` after 5 bytes of pair 2.
  - Response: all outputs return to their reset values.
  - The next 8 bytes produce a clean pair with `op_first`=1.
- **`WORDS`=1:**
  - Stimulus: three consecutive pairs.
  - Response: each has `op_first`=`op_last`=1.
  - `busy` is 0 in the first LOAD cycle after each handshake.
